fpu_dp_add_pipe: RTL and testbench
==================================

// Module: fpu_dp_add_pipe
// PURPOSE
//  Pipelined IEEE-754 binary64 adder: computes a + b.
//  Forward-direction counterpart to the combinational double-precision subtractor in the FPU datapath.
//  Uses a 3-stage pipeline (align / add / normalize-pack) with valid/ready handshakes on both sides.
//  Sits between the FPU operand issue logic and the result writeback.
// PARAMETERS
//  EXP_W   11  exponent width (fixed for binary64; width constants come from the package)
//  MAN_W   52  stored mantissa width
//  SHIFT_SAT 55  alignment shift at or above which the smaller operand becomes zero
// PORTS
//  clk        in   1   clock; all state changes on the rising edge
//  rst        in   1   reset, synchronous, active-high
//  in_valid   in   1   a/b valid this cycle
//  in_ready   out  1   pipeline accepts a/b this cycle
//  a          in   64  operand A, binary64
//  b          in   64  operand B, binary64
//  out_valid  out  1   result/flags valid
//  out_ready  in   1   downstream accepts result
//  result     out  64  a + b, binary64
//  overflow   out  1   result saturated to infinity
//  underflow  out  1   nonzero result flushed to zero
// BEHAVIOUR
//  Reset:
//   - s1/s2/s3 valid bits, out_valid, result, overflow, underflow all 0.
//   - in_ready is 1 in the cycle after rst deasserts.
//   - rst mid-operation discards all in-flight operations; no partial result is ever emitted.
//  Handshake:
//   - Global advance enable: en = ~out_valid | out_ready; in_ready = en.
//   - Transfer in on in_valid & in_ready. Transfer out on out_valid & out_ready.
//   - When en=0 every stage holds, and result/flags stay stable while out_valid=1 and out_ready=0.
//   - Bubbles are not compressed. Results emerge in issue order.
//  Latency: exactly 3 cycles from input transfer to out_valid when out_ready is held 1.
//   Throughput is 1 operation per cycle.
//  S1 (unpack/align):
//   - Hidden bit = (exp != 0).
//   - exp == 0 is treated as zero (subnormal inputs are flushed).
//   - Swap so operand 1 has the larger exponent; on equal exponents, the larger mantissa.
//   - Shift operand 2 right by d = e1 - e2. If d >= SHIFT_SAT, operand 2 becomes 0.
//   - Keep 53-bit mantissas plus one guard bit; truncate beyond that.
//  S2 (add):
//   - Same signs: 55-bit sum. Different signs: m1 - m2, which is never negative after the swap.
//   - Result sign = sign of operand 1.
//  S3 (normalize/pack):
//   - Carry out: shift right 1, exp + 1.
//   - Otherwise shift left by the leading-zero count, exp - lzc.
//   - Rounding is truncation (round toward zero).
//  Boundary cases:
//   - Exact cancellation (sum 0) -> +0 (0x0000000000000000), no flags.
//   - exp >= 2047 after normalization -> {sign, 11'h7FF, 52'h0}, overflow=1.
//   - exp <= 0 with a nonzero sum -> {sign, 63'h0}, underflow=1.
//   - Any NaN input, or +inf + -inf -> 0x7FF8000000000000, no flags.
//   - Otherwise, any inf input -> that inf, no flags.
//   - Flags are valid only while out_valid=1; they are 0 otherwise.
// STRUCTURE
//  - Shared package fpu_dp_pkg holds:
//     - DP_EXP_W=11, DP_MAN_W=52, DP_BIAS=1023
//     - DP_EXP_MAX=11'h7FF, DP_QNAN=64'h7FF8000000000000
//     - typedef fp64_t {sign, exp, man}
//  - One sub-module: fpu_lzc #(.W(55)), a combinational leading-zero counter used in S3.
//  - The pipeline control (en / valid chain) lives in this module.
// TESTING
//  1. 0x3FF0000000000000 + 0x3FF0000000000000 -> 0x4000000000000000 on cycle 3, no flags.
//  2. 0x3FF0000000000000 + 0xBFF0000000000000 -> 0x0000000000000000, overflow=0, underflow=0.
//  3. 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF -> 0x7FF0000000000000, overflow=1.
//  4. 0x0010000000000001 + 0x8010000000000000 -> 0x0000000000000000, underflow=1.
//     Also: 0x3FF0000000000000 + 0x3C30000000000000 -> 0x3FF0000000000000 (shift saturation).
//  5. Back-pressure: issue 4 ops back-to-back, hold out_ready=0 for 5 cycles.
//     -> in_ready drops to 0, result is stable, all 4 results arrive in order once out_ready=1.
//  6. Assert rst for one cycle with 3 ops in flight.
//     -> out_valid=0 next cycle, no stale result ever appears, and a fresh op completes in 3 cycles.

Source files
------------

// File: rtl/fpu_dp_pkg.sv
// ============================================================================
//  Module      : fpu_dp_pkg
//  Description : Shared binary64 constants, operand type and classify helpers
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fpu_dp_pkg;

    localparam int          DP_EXP_W   = 11;
    localparam int          DP_MAN_W   = 52;
    localparam int          DP_BIAS    = 1023;
    localparam logic [10:0] DP_EXP_MAX = 11'h7FF;
    localparam logic [63:0] DP_QNAN    = 64'h7FF8000000000000;

    typedef struct packed {
        logic                sign;
        logic [DP_EXP_W-1:0] exp;
        logic [DP_MAN_W-1:0] man;
    } fp64_t;

    function automatic logic fp_is_nan(input fp64_t v);
        return (v.exp == DP_EXP_MAX) && (v.man != '0);
    endfunction

    function automatic logic fp_is_inf(input fp64_t v);
        return (v.exp == DP_EXP_MAX) && (v.man == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_lzc.sv
// ============================================================================
//  Module      : fpu_lzc
//  Description : Combinational leading-zero counter (returns W for all-zero)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_lzc #(
    parameter int W     = 55,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        count = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CNT_W'(W - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_dp_add_pipe.sv
// ============================================================================
//  Module      : fpu_dp_add_pipe
//  Description : 3-stage pipelined binary64 adder (align / add / normalize-pack)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_dp_add_pipe
    import fpu_dp_pkg::*;
#(
    parameter int EXP_W     = DP_EXP_W,
    parameter int MAN_W     = DP_MAN_W,
    parameter int SHIFT_SAT = 55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        overflow,
    output logic        underflow
);

    localparam int SIG_W = MAN_W + 2;   // hidden + stored + guard
    localparam int SUM_W = SIG_W + 1;   // plus carry
    localparam int LZC_W = $clog2(SUM_W + 1);
    localparam int NE_W  = EXP_W + 2;
    localparam logic [EXP_W-1:0] C_SHIFT_SAT = EXP_W'(SHIFT_SAT);

    logic w_en;

    // ---------------- S1: unpack / swap / align ----------------
    fp64_t             w_a, w_b;
    logic [MAN_W-1:0]  w_ma, w_mb;
    logic              w_swap;
    logic              w_sgn1, w_sgn2;
    logic [EXP_W-1:0]  w_e1, w_e2, w_d;
    logic [MAN_W-1:0]  w_m1, w_m2;
    logic [SIG_W-1:0]  w_sig1, w_sig2, w_sig2_sh;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic              w_special;
    logic [63:0]       w_special_val;

    assign w_a  = a;
    assign w_b  = b;
    assign w_ma = (w_a.exp == '0) ? '0 : w_a.man;
    assign w_mb = (w_b.exp == '0) ? '0 : w_b.man;

    assign w_swap = {w_b.exp, w_mb} > {w_a.exp, w_ma};
    assign w_sgn1 = w_swap ? w_b.sign : w_a.sign;
    assign w_sgn2 = w_swap ? w_a.sign : w_b.sign;
    assign w_e1   = w_swap ? w_b.exp  : w_a.exp;
    assign w_e2   = w_swap ? w_a.exp  : w_b.exp;
    assign w_m1   = w_swap ? w_mb     : w_ma;
    assign w_m2   = w_swap ? w_ma     : w_mb;

    assign w_sig1    = {(w_e1 != '0), w_m1, 1'b0};
    assign w_sig2    = {(w_e2 != '0), w_m2, 1'b0};
    assign w_d       = w_e1 - w_e2;
    assign w_sig2_sh = (w_d >= C_SHIFT_SAT) ? '0 : (w_sig2 >> w_d);

    assign w_a_nan   = fp_is_nan(w_a);
    assign w_b_nan   = fp_is_nan(w_b);
    assign w_a_inf   = fp_is_inf(w_a);
    assign w_b_inf   = fp_is_inf(w_b);
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf;

    always_comb begin
        w_special_val = w_b;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a.sign != w_b.sign))) begin
            w_special_val = DP_QNAN;
        end else if (w_a_inf) begin
            w_special_val = w_a;
        end
    end

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic             r_s1_sub;
    logic [EXP_W-1:0] r_s1_exp;
    logic [SIG_W-1:0] r_s1_sig1, r_s1_sig2;
    logic             r_s1_special;
    logic [63:0]      r_s1_special_val;

    // ---------------- S2: add / subtract ----------------
    logic [SUM_W-1:0] w_sum;

    assign w_sum = r_s1_sub ? ({1'b0, r_s1_sig1} - {1'b0, r_s1_sig2})
                            : ({1'b0, r_s1_sig1} + {1'b0, r_s1_sig2});

    logic             r_s2_valid;
    logic             r_s2_sign;
    logic [EXP_W-1:0] r_s2_exp;
    logic [SUM_W-1:0] r_s2_sum;
    logic             r_s2_special;
    logic [63:0]      r_s2_special_val;

    // ---------------- S3: normalize / pack ----------------
    logic [LZC_W-1:0] w_lzc;
    logic [SUM_W-1:0] w_norm;
    logic [NE_W-1:0]  w_norm_exp;
    logic             w_exp_ovf, w_exp_unf;
    logic [63:0]      w_res;
    logic             w_ovf, w_unf;
    logic             w_unused;

    fpu_lzc #(
        .W     (SUM_W),
        .CNT_W (LZC_W)
    ) u_lzc (
        .value (r_s2_sum),
        .count (w_lzc)
    );

    // Leading one lands at the carry position; carry-out is simply lzc == 0.
    assign w_norm     = r_s2_sum << w_lzc;
    assign w_norm_exp = NE_W'(r_s2_exp) + NE_W'(1) - NE_W'(w_lzc);
    assign w_exp_ovf  = !w_norm_exp[NE_W-1] && (w_norm_exp[NE_W-2:0] >= (NE_W-1)'(DP_EXP_MAX));
    assign w_exp_unf  = w_norm_exp[NE_W-1] || (w_norm_exp == '0);
    assign w_unused   = ^{w_norm[SUM_W-1], w_norm[1:0]};

    always_comb begin
        w_res = {r_s2_sign, w_norm_exp[EXP_W-1:0], w_norm[SUM_W-2 -: MAN_W]};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (r_s2_special) begin
            w_res = r_s2_special_val;
        end else if (r_s2_sum == '0) begin
            w_res = '0;
        end else if (w_exp_ovf) begin
            w_res = {r_s2_sign, DP_EXP_MAX, MAN_W'(0)};
            w_ovf = 1'b1;
        end else if (w_exp_unf) begin
            w_res = {r_s2_sign, 63'h0};
            w_unf = 1'b1;
        end
    end

    logic        r_s3_valid;
    logic [63:0] r_result;
    logic        r_overflow, r_underflow;

    // ---------------- pipeline control ----------------
    assign w_en = ~r_s3_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_en) begin
            r_s1_valid       <= in_valid;
            r_s1_sign        <= w_sgn1;
            r_s1_sub         <= w_sgn1 ^ w_sgn2;
            r_s1_exp         <= w_e1;
            r_s1_sig1        <= w_sig1;
            r_s1_sig2        <= w_sig2_sh;
            r_s1_special     <= w_special;
            r_s1_special_val <= w_special_val;

            r_s2_valid       <= r_s1_valid;
            r_s2_sign        <= r_s1_sign;
            r_s2_exp         <= r_s1_exp;
            r_s2_sum         <= w_sum;
            r_s2_special     <= r_s1_special;
            r_s2_special_val <= r_s1_special_val;

            r_s3_valid       <= r_s2_valid;
            r_result         <= w_res;
            r_overflow       <= r_s2_valid & w_ovf;
            r_underflow      <= r_s2_valid & w_unf;
        end
    end

    assign in_ready  = w_en;
    assign out_valid = r_s3_valid;
    assign result    = r_result;
    assign overflow  = r_overflow  & r_s3_valid;
    assign underflow = r_underflow & r_s3_valid;

endmodule

`default_nettype wire

// File: tb/tb_fpu_dp_add_pipe.sv
// ============================================================================
//  Module      : tb_fpu_dp_add_pipe
//  Description : Directed-vector bench for the pipelined binary64 adder
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fpu_dp_add_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        overflow, underflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        ovf;
        logic        unf;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];
    vec_t bp[4];

    always #5 clk = ~clk;

    fpu_dp_add_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Single op on an idle pipe: exact latency, result, flags, drain.
    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        logic flag_bad;
        a         = v.a;
        b         = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check1($sformatf("v%0d_in_ready", idx), in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        lat      = 1;
        flag_bad = 1'b0;
        while (!out_valid && lat < 20) begin
            if (overflow || underflow) flag_bad = 1'b1;
            tick();
            lat++;
        end
        check64($sformatf("v%0d_latency", idx), 64'(lat), 64'd3);
        check64($sformatf("v%0d_result", idx), result, v.res);
        check1($sformatf("v%0d_overflow", idx), overflow, v.ovf);
        check1($sformatf("v%0d_underflow", idx), underflow, v.unf);
        check1($sformatf("v%0d_idle_flags", idx), flag_bad, 1'b0);
        tick();
        check1($sformatf("v%0d_drained", idx), out_valid, 1'b0);
    endtask

    initial begin
        int   issued, got;
        logic xfer_in, saw_stall, stable_bad, held, stale;
        logic [63:0] held_res;

        vecs[0]  = '{64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 1'b0};
        vecs[1]  = '{64'h3FF0000000000000, 64'hBFF0000000000000, 64'h0000000000000000, 1'b0, 1'b0};
        vecs[2]  = '{64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 64'h7FF0000000000000, 1'b1, 1'b0};
        vecs[3]  = '{64'h0010000000000001, 64'h8010000000000000, 64'h0000000000000000, 1'b0, 1'b1};
        vecs[4]  = '{64'h3FF0000000000000, 64'h3C30000000000000, 64'h3FF0000000000000, 1'b0, 1'b0};
        vecs[5]  = '{64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 1'b0, 1'b0};
        vecs[6]  = '{64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 1'b0, 1'b0};
        vecs[7]  = '{64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, 1'b0, 1'b0};
        vecs[8]  = '{64'hFFF0000000000000, 64'h4014000000000000, 64'hFFF0000000000000, 1'b0, 1'b0};
        vecs[9]  = '{64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, 1'b0, 1'b0};
        vecs[10] = '{64'h4000000000000000, 64'hBFE0000000000000, 64'h3FF8000000000000, 1'b0, 1'b0};
        vecs[11] = '{64'hBFF0000000000000, 64'hBFF0000000000000, 64'hC000000000000000, 1'b0, 1'b0};
        vecs[12] = '{64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FF0000000000000, 1'b0, 1'b0};
        vecs[13] = '{64'h3FF0000000000000, 64'h3FEFFFFFFFFFFFFF, 64'h3FFFFFFFFFFFFFFF, 1'b0, 1'b0};
        vecs[14] = '{64'h000FFFFFFFFFFFFF, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 1'b0};
        vecs[15] = '{64'h8000000000000000, 64'h8000000000000000, 64'h0000000000000000, 1'b0, 1'b0};
        vecs[16] = '{64'h3FF0000000000000, 64'hC000000000000000, 64'hBFF0000000000000, 1'b0, 1'b0};
        vecs[17] = '{64'hFFEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 64'hFFF0000000000000, 1'b1, 1'b0};

        bp[0] = vecs[0];
        bp[1] = vecs[9];
        bp[2] = vecs[10];
        bp[3] = vecs[11];

        // Reset state
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) tick();
        check1("rst_out_valid", out_valid, 1'b0);
        check64("rst_result", result, 64'h0);
        check1("rst_overflow", overflow, 1'b0);
        check1("rst_underflow", underflow, 1'b0);
        rst = 1'b0;
        tick();
        check1("post_rst_in_ready", in_ready, 1'b1);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-pressure: 4 back-to-back ops, out_ready low for the first 5 cycles
        issued     = 0;
        got        = 0;
        saw_stall  = 1'b0;
        stable_bad = 1'b0;
        held       = 1'b0;
        held_res   = '0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            out_ready = (cyc >= 5);
            if (issued < 4) begin
                a        = bp[issued].a;
                b        = bp[issued].b;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            xfer_in = in_valid && in_ready;
            if (!in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                check64($sformatf("bp_result%0d", got), result, bp[got].res);
                got++;
                held = 1'b0;
            end else if (out_valid) begin
                if (held && (result !== held_res)) stable_bad = 1'b1;
                held     = 1'b1;
                held_res = result;
            end
            tick();
            if (xfer_in) issued++;
        end
        in_valid = 1'b0;
        check64("bp_count", 64'(got), 64'd4);
        check1("bp_in_ready_dropped", saw_stall, 1'b1);
        check1("bp_result_stable", stable_bad, 1'b0);

        // Reset with three ops in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a        = bp[k].a;
            b        = bp[k].b;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check1("flush_pipe_full", out_valid, 1'b1);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        check1("flush_out_valid", out_valid, 1'b0);
        check64("flush_result", result, 64'h0);
        rst   = 1'b0;
        stale = 1'b0;
        repeat (5) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        check1("flush_no_stale", stale, 1'b0);
        run_vec(vecs[16], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
